// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory word port between c0 (icache) and c1 (dcache)
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   cN_rden/cN_wren                  level requests held until cN_ack (N = 0, 1)
//   cN_address/cN_din                request word address and write data
//   cN_ack/cN_q                      one-cycle completion pulse and read data (held until next read ack)
//   mrden/mwren/maddress/mdout       one-cycle memory strobes with address/data
//   mq                               memory read data, valid MEM_LATENCY cycles after the strobe
//   busy/grant                       transaction in flight and its owner (0 = c0, 1 = c1)
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (c1 wins ties); default is round-robin.
module mem_port_arbiter #(
    parameter int MEM_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c0_rden,
    input  logic                  c0_wren,
    input  logic [ADDR_WIDTH-1:0] c0_address,
    input  logic [MEM_WIDTH-1:0]  c0_din,
    output logic                  c0_ack,
    output logic [MEM_WIDTH-1:0]  c0_q,
    input  logic                  c1_rden,
    input  logic                  c1_wren,
    input  logic [ADDR_WIDTH-1:0] c1_address,
    input  logic [MEM_WIDTH-1:0]  c1_din,
    output logic                  c1_ack,
    output logic [MEM_WIDTH-1:0]  c1_q,
    output logic                  mrden,
    output logic                  mwren,
    output logic [ADDR_WIDTH-1:0] maddress,
    output logic [MEM_WIDTH-1:0]  mdout,
    input  logic [MEM_WIDTH-1:0]  mq,
    output logic                  busy,
    output logic                  grant
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

    logic [1:0]            state_q, state_d;
    logic                  own_q, own_d;
    logic                  wr_q, wr_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  c0_ack_q, c0_ack_d, c1_ack_q, c1_ack_d;
    logic [MEM_WIDTH-1:0]  c0_data_q, c0_data_d, c1_data_q, c1_data_d;
    logic                  mrden_q, mrden_d, mwren_q, mwren_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [MEM_WIDTH-1:0]  mdout_q, mdout_d;
    logic                  busy_q, busy_d, grant_q, grant_d;
    logic                  c0_req, c1_req, win, win_wr;

    assign c0_req = c0_rden | c0_wren;
    assign c1_req = c1_rden | c1_wren;
`ifdef ARB_FIXED_PRIO_EN
    assign win = c1_req;
`else
    logic rr_q, rr_d;
    // rr_q names the port favoured on a tie; it only matters when both request
    assign win = (c0_req & c1_req) ? rr_q : c1_req;
`endif
    // write wins when a port raises both rden and wren
    assign win_wr = win ? c1_wren : c0_wren;

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        c0_ack_d  = 1'b0;
        c1_ack_d  = 1'b0;
        c0_data_d = c0_data_q;
        c1_data_d = c1_data_q;
        mrden_d   = 1'b0;
        mwren_d   = 1'b0;
        maddr_d   = maddr_q;
        mdout_d   = mdout_q;
        busy_d    = busy_q;
        grant_d   = grant_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (c0_req | c1_req) begin
                    state_d = ISSUE;
                    own_d   = win;
                    wr_d    = win_wr;
                    mrden_d = ~win_wr;
                    mwren_d = win_wr;
                    maddr_d = win ? c1_address : c0_address;
                    mdout_d = win_wr ? (win ? c1_din : c0_din) : '0;
                    busy_d  = 1'b1;
                    grant_d = win;
`ifndef ARB_FIXED_PRIO_EN
                    rr_d    = ~win;
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // last wait cycle: mq is valid now, so ack and data land together in DONE
                if (cnt_q == 4'd1) begin
                    state_d   = DONE;
                    c0_ack_d  = ~own_q;
                    c1_ack_d  = own_q;
                    c0_data_d = (!wr_q && !own_q) ? mq : c0_data_q;
                    c1_data_d = (!wr_q && own_q) ? mq : c1_data_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            c0_ack_q  <= 1'b0;
            c1_ack_q  <= 1'b0;
            c0_data_q <= '0;
            c1_data_q <= '0;
            mrden_q   <= 1'b0;
            mwren_q   <= 1'b0;
            maddr_q   <= '0;
            mdout_q   <= '0;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            c0_ack_q  <= c0_ack_d;
            c1_ack_q  <= c1_ack_d;
            c0_data_q <= c0_data_d;
            c1_data_q <= c1_data_d;
            mrden_q   <= mrden_d;
            mwren_q   <= mwren_d;
            maddr_q   <= maddr_d;
            mdout_q   <= mdout_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign c0_ack   = c0_ack_q;
    assign c1_ack   = c1_ack_q;
    assign c0_q     = c0_data_q;
    assign c1_q     = c1_data_q;
    assign mrden    = mrden_q;
    assign mwren    = mwren_q;
    assign maddress = maddr_q;
    assign mdout    = mdout_q;
    assign busy     = busy_q;
    assign grant    = grant_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; instance 0 uses MEM_LATENCY=2, instances 1/2 use 1 and 5
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        bit            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } item_t;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 5;
    endfunction

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a == 16'h1234) ? 32'hCAFEBABE : {~a, a};
    endfunction

    logic clk = 1'b0;
    logic rst;
    logic c0_rden = 1'b0, c0_wren = 1'b0, c1_rden = 1'b0, c1_wren = 1'b0;
    logic [AW-1:0] c0_address = '0, c1_address = '0;
    logic [DW-1:0] c0_din = '0, c1_din = '0;
    logic c0_ack [3];
    logic c1_ack [3];
    logic mrden [3];
    logic mwren [3];
    logic busy [3];
    logic grant [3];
    logic [DW-1:0] c0_q [3];
    logic [DW-1:0] c1_q [3];
    logic [DW-1:0] mdout [3];
    logic [AW-1:0] maddress [3];

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    item_t ack_q[$];
    item_t mem_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = lat_of(g);
        int rd_cyc = -100;
        logic [AW-1:0] rd_addr = '0;
        logic [DW-1:0] mq_l;
        // memory returns real data only in the exact cycle it is due
        assign mq_l = (cyc == rd_cyc + L) ? mem_data(rd_addr) : (32'h0BAD0000 | 32'(cyc & 16'hFFFF));
        always @(posedge clk) begin
            if (mrden[g]) begin
                rd_cyc  <= cyc;
                rd_addr <= maddress[g];
            end
        end
        mem_port_arbiter #(.MEM_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(L)) u_dut (
            .clk(clk), .rst(rst),
            .c0_rden(c0_rden), .c0_wren(c0_wren), .c0_address(c0_address), .c0_din(c0_din),
            .c0_ack(c0_ack[g]), .c0_q(c0_q[g]),
            .c1_rden(c1_rden), .c1_wren(c1_wren), .c1_address(c1_address), .c1_din(c1_din),
            .c1_ack(c1_ack[g]), .c1_q(c1_q[g]),
            .mrden(mrden[g]), .mwren(mwren[g]), .maddress(maddress[g]), .mdout(mdout[g]),
            .mq(mq_l), .busy(busy[g]), .grant(grant[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // expected memory strobe at strobe cycle s and ack at s+3 (MEM_LATENCY=2)
    task automatic push_txn(input bit p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int s);
        mem_q.push_back('{p, wr, a, wr ? d : '0, s});
        ack_q.push_back('{p, wr, a, wr ? '0 : mem_data(a), s + 3});
    endtask

    task automatic set_req(input bit p, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin
            c1_rden = rd; c1_wren = wr; c1_address = a; c1_din = d;
        end else begin
            c0_rden = rd; c0_wren = wr; c0_address = a; c0_din = d;
        end
    endtask

    task automatic req(input bit p, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_req(p, rd, wr, a, d);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p ? c1_ack[0] : c0_ack[0]) begin
                set_req(p, 1'b0, 1'b0, a, d);
                return;
            end
        end
        bad(p ? "ack_timeout_c1" : "ack_timeout_c0");
        set_req(p, 1'b0, 1'b0, a, d);
    endtask

    logic [DW-1:0] exp_q0 = '0, exp_q1 = '0;
    bit gap_chk = 0;
    item_t ia, im;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q0 = '0;
            exp_q1 = '0;
            gap_chk = 0;
        end else begin
            if (gap_chk) chk("idle_gap_busy", busy[0], 0);
            gap_chk = c0_ack[0] | c1_ack[0];
            if (c0_ack[0] | c1_ack[0]) begin
                if (ack_q.size() == 0) bad("spurious_ack");
                else begin
                    ia = ack_q.pop_front();
                    chk("ack_port", {c1_ack[0], c0_ack[0]}, ia.port ? 2'b10 : 2'b01);
                    chk("ack_cycle", cyc, ia.cyc);
                    if (!ia.wr && ia.port) exp_q1 = ia.data;
                    if (!ia.wr && !ia.port) exp_q0 = ia.data;
                    chk("q_regs", {c0_q[0], c1_q[0]}, {exp_q0, exp_q1});
                end
            end
            if (mrden[0] | mwren[0]) begin
                if (mem_q.size() == 0) bad("spurious_strobe");
                else begin
                    im = mem_q.pop_front();
                    chk("strobe_op", {mwren[0], mrden[0]}, im.wr ? 2'b10 : 2'b01);
                    chk("maddress", maddress[0], im.addr);
                    chk("mdout", mdout[0], im.data);
                    chk("strobe_cycle", cyc, im.cyc);
                    chk("busy_grant", {busy[0], grant[0]}, {1'b1, im.port});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, a1, a5;
        logic [DW-1:0] q1, q5;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {c0_ack[0], c1_ack[0], mrden[0], mwren[0], busy[0], grant[0], maddress[0]}, 0);
        chk("reset_q", {c0_q[0], c1_q[0], mdout[0]}, 0);
        rst = 1'b1;
        @(negedge clk);

        // contention: both ports keep reading, two transactions each
        c = cyc;
`ifdef ARB_FIXED_PRIO_EN
        push_txn(1, 0, 16'h0200, 0, c + 1);
        push_txn(1, 0, 16'h0201, 0, c + 6);
        push_txn(0, 0, 16'h0100, 0, c + 11);
        push_txn(0, 0, 16'h0101, 0, c + 16);
`else
        push_txn(0, 0, 16'h0100, 0, c + 1);
        push_txn(1, 0, 16'h0200, 0, c + 6);
        push_txn(0, 0, 16'h0101, 0, c + 11);
        push_txn(1, 0, 16'h0201, 0, c + 16);
`endif
        fork
            begin
                req(0, 1, 0, 16'h0100, 0);
                req(0, 1, 0, 16'h0101, 0);
            end
            begin
                req(1, 1, 0, 16'h0200, 0);
                req(1, 1, 0, 16'h0201, 0);
            end
        join
        @(negedge clk);

        // single read
        c = cyc;
        push_txn(0, 0, 16'h1234, 0, c + 1);
        req(0, 1, 0, 16'h1234, 0);
        @(negedge clk);

        // single write from c1
        c = cyc;
        push_txn(1, 1, 16'h00FF, 32'hDEADBEEF, c + 1);
        req(1, 0, 1, 16'h00FF, 32'hDEADBEEF);
        @(negedge clk);

        // rden and wren together: write wins
        c = cyc;
        push_txn(0, 1, 16'h0055, 32'h12345678, c + 1);
        req(0, 1, 1, 16'h0055, 32'h12345678);
        @(negedge clk);

        // reset in the middle of WAIT: strobe seen, no ack
        c = cyc;
        mem_q.push_back('{0, 0, 16'h0777, '0, c + 1});
        set_req(0, 1, 0, 16'h0777, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        set_req(0, 0, 0, 16'h0777, 0);
        #1;
        chk("abort_ctrl", {c0_ack[0], c1_ack[0], mrden[0], mwren[0], busy[0], grant[0], maddress[0]}, 0);
        chk("abort_q", {c0_q[0], c1_q[0], mdout[0]}, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        c = cyc;
        push_txn(0, 0, 16'h0010, 0, c + 1);
        req(0, 1, 0, 16'h0010, 0);
        repeat (10) @(negedge clk);

        // latency sweep: one-cycle request pulse seen by all three instances together
        c = cyc;
        a1 = -1;
        a5 = -1;
        q1 = '0;
        q5 = '0;
        push_txn(0, 0, 16'h0042, 0, c + 1);
        set_req(0, 1, 0, 16'h0042, 0);
        @(negedge clk);
        set_req(0, 0, 0, 16'h0042, 0);
        for (int i = 0; i < 12; i++) begin
            if (c0_ack[1]) begin a1 = cyc; q1 = c0_q[1]; end
            if (c0_ack[2]) begin a5 = cyc; q5 = c0_q[2]; end
            @(negedge clk);
        end
        chk("lat1_ack_cycle", a1, c + 3);
        chk("lat1_data", q1, mem_data(16'h0042));
        chk("lat5_ack_cycle", a5, c + 7);
        chk("lat5_data", q5, mem_data(16'h0042));

        repeat (3) @(negedge clk);
        chk("ack_queue_empty", ack_q.size(), 0);
        chk("mem_queue_empty", mem_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory word port between two cache-side requesters: c0 (instruction cache) and c1 (data cache).
- Each requester holds a read or write request until it receives a one-cycle ack. For reads, the returned word is presented with the ack.
- Serialises requests with round-robin arbitration and drives the memory strobes for exactly one cycle per transaction.
- Counts the fixed memory latency before completing each transaction.

Parameters:
- MEM_WIDTH, 32: data word width.
- ADDR_WIDTH, 16: word address width on the memory side.
- MEM_LATENCY, 2: cycles from a sampled strobe to valid mq or write completion. Legal range is 1 to 15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- c0_rden  in  1  c0 read request (level, held until ack).
- c0_wren  in  1  c0 write request (level, held until ack).
- c0_address  in  ADDR_WIDTH  c0 word address.
- c0_din  in  MEM_WIDTH  c0 write data.
- c0_ack  out  1  one-cycle completion pulse to c0.
- c0_q  out  MEM_WIDTH  c0 read data; valid with c0_ack and held until c0's next read ack.
- c1_rden, c1_wren, c1_address, c1_din, c1_ack, c1_q: same as the c0 ports, for c1.
- mrden  out  1  memory read strobe.
- mwren  out  1  memory write strobe.
- maddress  out  ADDR_WIDTH  memory word address.
- mdout  out  MEM_WIDTH  memory write data.
- mq  in  MEM_WIDTH  memory read data.
- busy  out  1  high in every state except IDLE.
- grant  out  1  owner of the current transaction (0 = c0, 1 = c1); valid while busy.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; rr_ptr = 0 (c0 favoured).
  - All outputs are 0: acks, q buses, strobes, maddress, mdout, busy, grant.
  - Reset during any state aborts the transaction with no ack. Outputs clear immediately, not on the next edge.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - A port is requesting when its rden or wren is high.
  - If both ports request, the winner is rr_ptr. Otherwise the single requester wins.
  - On the edge: latch the winner's id, address, din and op (wren takes precedence if both rden and wren are high); set rr_ptr to the non-winner; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (1 cycle):
  - mrden or mwren = 1; maddress and mdout driven from the latch (mdout is 0 for reads).
  - Latency counter loaded with MEM_LATENCY; go to WAIT.
- WAIT:
  - Strobes are 0; maddress is held; the counter decrements each cycle.
  - When the counter reaches 1: for a read, capture mq into the owner's q register; go to DONE.
  - Consequence: mq is sampled exactly MEM_LATENCY cycles after the ISSUE cycle.
- DONE (1 cycle):
  - The owner's ack = 1. The owner's q already holds the new data for a read and is unchanged for a write.
  - Next state is IDLE. The arbiter does not re-arbitrate in DONE; the requester drops its request after sampling the ack.
- Read latency: request high at edge 0 → ISSUE at cycle 1 → ack at cycle MEM_LATENCY+2 (4 cycles at the default).
- Throughput: at most one transaction per MEM_LATENCY+3 cycles.
- A request that drops mid-transaction still completes on memory and still receives its ack. The request inputs are don't-care after the IDLE sample.
- The non-owner's ack and q are never disturbed.
- The non-owner's request waits. The owner cannot be granted twice in a row while the other port is requesting, so neither port starves.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, c1 wins every simultaneous request; rr_ptr is removed.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset: drive rst low mid-WAIT → all outputs 0 immediately, no ack; after release, a c0 read of 0x0010 completes normally.
- Single read: c0_rden=1, c0_address=0x1234, memory returns 0xCAFEBABE at MEM_LATENCY=2 → mrden pulse at cycle 1 with maddress=0x1234; c0_ack at cycle 4 with c0_q=0xCAFEBABE.
- Single write: c1_wren=1, c1_address=0x00FF, c1_din=0xDEADBEEF → one-cycle mwren with maddress=0x00FF and mdout=0xDEADBEEF; c1_ack at cycle 4; c0_q and c1_q unchanged.
- Contention: c0 and c1 both read continuously from reset → grants alternate c0, c1, c0, c1; each ack pairs with its own port's data; busy is low for one cycle between transactions.
- Rd+wr same port: c0_rden=c0_wren=1 → a write is performed; no mrden is issued.
- Latency sweep: MEM_LATENCY=1 and 5 → ack at cycles 3 and 7; mq sampled exactly MEM_LATENCY cycles after the strobe.
- Feature: with ARB_FIXED_PRIO_EN and both ports requesting → c1 is granted every time.
